// File: rtl/lane_traffic_gen.sv
// Obstacle generator for the road/river playfield: per-lane speed dividers step
// CARS_PER_LANE equal-length objects one pixel at a time, with edge wrap-around.
module lane_traffic_gen #(
  parameter int NUM_LANES     = 6,
  parameter int CARS_PER_LANE = 2,
  parameter int X_W           = 10,
  parameter int DIV_W         = 24,
  parameter int X_LEFT        = 96,
  parameter int X_RIGHT       = 544,
  parameter int SPACING       = 150,
  parameter int LVL_SHIFT_MAX = 3,
  parameter int MIN_DIV       = 2,
  localparam int NC_W         = $clog2(CARS_PER_LANE + 1)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 load,
  input  logic                                 pause,
  input  logic [3:0]                           level,
  input  logic [NUM_LANES*X_W-1:0]             cfg_len,
  input  logic [NUM_LANES*DIV_W-1:0]           cfg_div,
  input  logic [NUM_LANES-1:0]                 cfg_dir,
  input  logic [NUM_LANES*NC_W-1:0]            cfg_ncars,
  output logic [NUM_LANES*CARS_PER_LANE*X_W-1:0] car_x,
  output logic [NUM_LANES*CARS_PER_LANE-1:0]   car_en,
  output logic [NUM_LANES*X_W-1:0]             lane_len,
  output logic [NUM_LANES-1:0]                 lane_step
);

  localparam logic [X_W-1:0]   X_LEFT_V  = X_W'(X_LEFT);
  localparam logic [X_W-1:0]   X_RIGHT_V = X_W'(X_RIGHT);
  localparam logic [X_W:0]     X_LEFT_W  = (X_W+1)'(X_LEFT);
  localparam logic [DIV_W-1:0] MIN_DIV_V = DIV_W'(MIN_DIV);
  localparam logic [3:0]       SHIFT_MAX = 4'(LVL_SHIFT_MAX);

  logic [3:0] shift;
  logic       restart;

  // Level only ever scales the divider down, so it is shared by all lanes.
  assign shift   = (level > SHIFT_MAX) ? SHIFT_MAX : level;
  assign restart = reset || load;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [X_W-1:0]   len_in;
    logic [DIV_W-1:0] div_in;
    logic [NC_W-1:0]  nc_in;
    logic [NC_W-1:0]  nc_clamp;
    logic [X_W-1:0]   len_r;
    logic [DIV_W-1:0] div_r;
    logic [DIV_W-1:0] cnt_r;
    logic             dir_r;
    logic             step_r;
    logic [DIV_W-1:0] div_sh;
    logic [DIV_W-1:0] div_eff;
    logic             hit;
    logic             advance;

    assign len_in   = cfg_len[i*X_W +: X_W];
    assign div_in   = cfg_div[i*DIV_W +: DIV_W];
    assign nc_in    = cfg_ncars[i*NC_W +: NC_W];
    assign nc_clamp = (int'(nc_in) > CARS_PER_LANE) ? NC_W'(CARS_PER_LANE) : nc_in;

    // NOTE: every signal driven in always_comb is assigned on all paths, so no latch is inferred.
    always_comb begin
      div_sh  = div_r >> shift;
      div_eff = (div_sh < MIN_DIV_V) ? MIN_DIV_V : div_sh;
      // >= rather than == so a faster level takes effect immediately mid-count.
      hit     = (cnt_r >= div_eff - DIV_W'(1));
    end

    assign advance = !pause && hit;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
      if (restart) begin
        len_r  <= len_in;
        div_r  <= div_in;
        dir_r  <= cfg_dir[i];
        cnt_r  <= '0;
        step_r <= 1'b0;
      end else if (!pause) begin
        step_r <= hit;
        cnt_r  <= hit ? '0 : cnt_r + DIV_W'(1);
      end else begin
        step_r <= 1'b0;
      end
    end

    assign lane_len[i*X_W +: X_W] = len_r;
    assign lane_step[i]           = step_r;

    for (genvar k = 0; k < CARS_PER_LANE; k++) begin : g_slot
      localparam logic [X_W-1:0] OFS = X_W'(k * SPACING);
      logic [X_W-1:0] x_r;
      logic           en_r;

      always_ff @(posedge clk) begin
        if (restart) begin
          en_r <= (int'(nc_clamp) > k);
          x_r  <= cfg_dir[i] ? (X_RIGHT_V - len_in - OFS) : (X_LEFT_V + OFS);
        end else if (advance && en_r) begin
          // A wrap replaces the pixel move for that step; it never adds to it.
          if (!dir_r)
            x_r <= (x_r >= X_RIGHT_V) ? (X_LEFT_V - len_r) : (x_r + X_W'(1));
          else
            x_r <= (({1'b0, x_r} + {1'b0, len_r}) <= X_LEFT_W) ? X_RIGHT_V : (x_r - X_W'(1));
        end
      end

      assign car_x[(i*CARS_PER_LANE+k)*X_W +: X_W] = x_r;
      assign car_en[i*CARS_PER_LANE+k]             = en_r;
    end
  end

endmodule

// File: tb/tb_lane_traffic_gen.sv
// Directed bench for lane_traffic_gen: stepping rates, level scaling, wrap,
// pause, slot enables, load/reset restart.
module tb_lane_traffic_gen;

  localparam int NL = 6;
  localparam int NC = 2;
  localparam int XW = 10;
  localparam int DW = 24;
  localparam int NCW = 2;
  localparam int BOUND = 200;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 load = 1'b0;
  logic                 pause = 1'b0;
  logic [3:0]           level = 4'd0;
  logic [NL*XW-1:0]     cfg_len = '0;
  logic [NL*DW-1:0]     cfg_div = '0;
  logic [NL-1:0]        cfg_dir = '0;
  logic [NL*NCW-1:0]    cfg_ncars = '0;
  logic [NL*NC*XW-1:0]  car_x;
  logic [NL*NC-1:0]     car_en;
  logic [NL*XW-1:0]     lane_len;
  logic [NL-1:0]        lane_step;

  int tests_run = 0;
  int tests_failed = 0;

  lane_traffic_gen dut (
    .clk(clk), .reset(reset), .load(load), .pause(pause), .level(level),
    .cfg_len(cfg_len), .cfg_div(cfg_div), .cfg_dir(cfg_dir), .cfg_ncars(cfg_ncars),
    .car_x(car_x), .car_en(car_en), .lane_len(lane_len), .lane_step(lane_step)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int get_x(input int lane, input int slot);
    return int'(car_x[(lane*NC+slot)*XW +: XW]);
  endfunction

  task automatic set_lane(input int lane, input int len, input int div, input bit dir, input int nc);
    cfg_len[lane*XW +: XW]     = XW'(len);
    cfg_div[lane*DW +: DW]     = DW'(div);
    cfg_dir[lane]              = dir;
    cfg_ncars[lane*NCW +: NCW] = NCW'(nc);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic do_load();
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic wait_step(input int lane, input string name);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!lane_step[lane] && n < BOUND);
    if (!lane_step[lane]) begin
      tests_run++;
      tests_failed++;
      $display("FAIL %s: no lane_step on lane %0d within %0d cycles", name, lane, BOUND);
    end
  endtask

  task automatic measure_period(input int lane, input int expected, input string name);
    int n;
    wait_step(lane, name);
    n = 0;
    do begin
      tick();
      n++;
    end while (!lane_step[lane] && n < BOUND);
    tests_run++;
    if (n !== expected) begin
      tests_failed++;
      $display("FAIL %s: period got %0d expected %0d", name, n, expected);
    end
  endtask

  task automatic default_cfg();
    for (int i = 0; i < NL; i++) set_lane(i, 16, 100, 1'b1, 1);
    set_lane(0, 32, 8, 1'b0, 2);
    set_lane(1, 32, 4, 1'b0, 2);
    level = 4'd0;
    pause = 1'b0;
  endtask

  task automatic test_reset();
    default_cfg();
    do_reset();
    tests_run++;
    if (lane_step !== '0) begin tests_failed++; $display("FAIL reset_step: got %b expected 0", lane_step); end
    tests_run++;
    if (get_x(0, 0) !== 96) begin tests_failed++; $display("FAIL reset_x00: got %0d expected 96", get_x(0, 0)); end
    tests_run++;
    if (get_x(0, 1) !== 246) begin tests_failed++; $display("FAIL reset_x01: got %0d expected 246", get_x(0, 1)); end
    tests_run++;
    if (get_x(2, 0) !== 528) begin tests_failed++; $display("FAIL reset_x20: got %0d expected 528", get_x(2, 0)); end
    tests_run++;
    if (get_x(2, 1) !== 378) begin tests_failed++; $display("FAIL reset_x21: got %0d expected 378", get_x(2, 1)); end
    tests_run++;
    if (car_en[5:4] !== 2'b01) begin tests_failed++; $display("FAIL reset_en2: got %b expected 01", car_en[5:4]); end
    tests_run++;
    if (lane_len[XW-1:0] !== 10'd32) begin tests_failed++; $display("FAIL reset_len0: got %0d expected 32", lane_len[XW-1:0]); end
  endtask

  task automatic test_basic_rate();
    default_cfg();
    do_reset();
    repeat (40) tick();
    tests_run++;
    if (get_x(1, 0) !== 106) begin tests_failed++; $display("FAIL rate_lane1: got %0d expected 106", get_x(1, 0)); end
    tests_run++;
    if (get_x(0, 0) !== 101) begin tests_failed++; $display("FAIL rate_lane0: got %0d expected 101", get_x(0, 0)); end
    tests_run++;
    if (get_x(1, 1) !== 256) begin tests_failed++; $display("FAIL rate_lane1_s1: got %0d expected 256", get_x(1, 1)); end
    tests_run++;
    if (lane_step[1:0] !== 2'b11) begin tests_failed++; $display("FAIL rate_step: got %b expected 11", lane_step[1:0]); end
  endtask

  task automatic test_level_sweep();
    int lv [5] = '{0, 1, 2, 3, 7};
    int per [5] = '{40, 20, 10, 5, 5};
    default_cfg();
    set_lane(0, 32, 40, 1'b0, 2);
    do_reset();
    for (int j = 0; j < 5; j++) begin
      level = 4'(lv[j]);
      do_load();
      measure_period(0, per[j], $sformatf("level_%0d", lv[j]));
    end
    set_lane(0, 32, 3, 1'b0, 2);
    level = 4'd3;
    do_load();
    measure_period(0, 2, "min_div");
    level = 4'd0;
  endtask

  task automatic test_wrap();
    default_cfg();
    set_lane(0, 32, 2, 1'b0, 2);
    set_lane(1, 32, 2, 1'b1, 2);
    do_reset();
    repeat (298) wait_step(0, "wrap_run");
    tests_run++;
    if (get_x(0, 1) !== 544) begin tests_failed++; $display("FAIL wrap_pre_r: got %0d expected 544", get_x(0, 1)); end
    tests_run++;
    if (get_x(1, 1) !== 64) begin tests_failed++; $display("FAIL wrap_pre_l: got %0d expected 64", get_x(1, 1)); end
    tests_run++;
    if (get_x(0, 0) !== 394 || get_x(1, 0) !== 214) begin
      tests_failed++;
      $display("FAIL wrap_slot0: got %0d/%0d expected 394/214", get_x(0, 0), get_x(1, 0));
    end
    wait_step(0, "wrap_step");
    tests_run++;
    if (lane_step[1:0] !== 2'b11) begin tests_failed++; $display("FAIL wrap_both_step: got %b expected 11", lane_step[1:0]); end
    tests_run++;
    if (get_x(0, 1) !== 64) begin tests_failed++; $display("FAIL wrap_right: got %0d expected 64", get_x(0, 1)); end
    tests_run++;
    if (get_x(1, 1) !== 544) begin tests_failed++; $display("FAIL wrap_left: got %0d expected 544", get_x(1, 1)); end
    wait_step(0, "wrap_after");
    tests_run++;
    if (get_x(0, 1) !== 65 || get_x(1, 1) !== 543) begin
      tests_failed++;
      $display("FAIL wrap_after: got %0d/%0d expected 65/543", get_x(0, 1), get_x(1, 1));
    end
  endtask

  task automatic test_pause();
    bit moved;
    int x_hold;
    default_cfg();
    do_reset();
    repeat (2) tick();
    pause = 1'b1;
    x_hold = get_x(1, 0);
    moved = 1'b0;
    repeat (100) begin
      tick();
      if (lane_step[1] || get_x(1, 0) != x_hold) moved = 1'b1;
    end
    tests_run++;
    if (moved !== 1'b0) begin tests_failed++; $display("FAIL pause_frozen: got activity=%0d expected 0", moved); end
    pause = 1'b0;
    tick();
    tests_run++;
    if (lane_step[1] !== 1'b0) begin tests_failed++; $display("FAIL pause_resume1: got %b expected 0", lane_step[1]); end
    tick();
    tests_run++;
    if (lane_step[1] !== 1'b1 || get_x(1, 0) !== 97) begin
      tests_failed++;
      $display("FAIL pause_resume2: got step=%b x=%0d expected step=1 x=97", lane_step[1], get_x(1, 0));
    end
  endtask

  task automatic test_ncars_load();
    default_cfg();
    set_lane(0, 32, 4, 1'b0, 1);
    set_lane(1, 32, 4, 1'b0, 3);
    do_reset();
    tests_run++;
    if (car_en[3:0] !== 4'b1101) begin tests_failed++; $display("FAIL ncars_en: got %b expected 1101", car_en[3:0]); end
    repeat (4) tick();
    tests_run++;
    if (get_x(0, 0) !== 97 || get_x(0, 1) !== 246) begin
      tests_failed++;
      $display("FAIL ncars_hold: got %0d/%0d expected 97/246", get_x(0, 0), get_x(0, 1));
    end
    repeat (2) tick();
    set_lane(0, 40, 4, 1'b1, 2);
    do_load();
    tests_run++;
    if (get_x(0, 0) !== 504 || get_x(0, 1) !== 354) begin
      tests_failed++;
      $display("FAIL load_place: got %0d/%0d expected 504/354", get_x(0, 0), get_x(0, 1));
    end
    tests_run++;
    if (lane_len[XW-1:0] !== 10'd40 || lane_step[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL load_len_step: got len=%0d step=%b expected len=40 step=0", lane_len[XW-1:0], lane_step[0]);
    end
    repeat (3) tick();
    tests_run++;
    if (lane_step[0] !== 1'b0) begin tests_failed++; $display("FAIL load_cnt_early: got %b expected 0", lane_step[0]); end
    tick();
    tests_run++;
    if (lane_step[0] !== 1'b1 || get_x(0, 0) !== 503) begin
      tests_failed++;
      $display("FAIL load_cnt_step: got step=%b x=%0d expected step=1 x=503", lane_step[0], get_x(0, 0));
    end
    set_lane(0, 20, 4, 1'b0, 2);
    reset = 1'b1;
    load = 1'b1;
    tick();
    reset = 1'b0;
    load = 1'b0;
    tests_run++;
    if (get_x(0, 0) !== 96 || lane_len[XW-1:0] !== 10'd20 || lane_step !== '0) begin
      tests_failed++;
      $display("FAIL reset_load: got x=%0d len=%0d step=%b expected x=96 len=20 step=0",
               get_x(0, 0), lane_len[XW-1:0], lane_step);
    end
  endtask

  task automatic test_level_change();
    default_cfg();
    set_lane(0, 32, 40, 1'b0, 2);
    do_reset();
    repeat (15) tick();
    level = 4'd2;
    tick();
    tests_run++;
    if (lane_step[0] !== 1'b1 || get_x(0, 0) !== 97) begin
      tests_failed++;
      $display("FAIL lvl_immediate: got step=%b x=%0d expected step=1 x=97", lane_step[0], get_x(0, 0));
    end
    repeat (9) tick();
    tests_run++;
    if (lane_step[0] !== 1'b0) begin tests_failed++; $display("FAIL lvl_early: got %b expected 0", lane_step[0]); end
    tick();
    tests_run++;
    if (lane_step[0] !== 1'b1 || get_x(0, 0) !== 98) begin
      tests_failed++;
      $display("FAIL lvl_period: got step=%b x=%0d expected step=1 x=98", lane_step[0], get_x(0, 0));
    end
    level = 4'd0;
  endtask

  initial begin
    test_reset();
    test_basic_rate();
    test_level_sweep();
    test_wrap();
    test_pause();
    test_ncars_load();
    test_level_change();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
